pixel_fifo: RTL and testbench
=============================

# pixel_fifo

Parametrised single-clock FIFO built on an inferred dual-port memory, replacing the bare dual-port RAM as the pixel buffer between the host-side write path and the RAMDAC scan-out path. It adds read/write pointer management, level tracking, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Read data is registered: one cycle of latency, qualified by a valid strobe.

## Interface
- DATA_WIDTH, 12, width of one pixel word.
- ADDRESS_SIZE, 13, log2 of depth; depth = 2**ADDRESS_SIZE entries.
- ALMOST_FULL_LEVEL, 2**ADDRESS_SIZE-16, almost_full asserted when level >= this value.
- ALMOST_EMPTY_LEVEL, 16, almost_empty asserted when level <= this value.

- clock  input  1  single clock for all logic and memory.
- reset  input  1  asynchronous, active-high; clears all state except memory contents.
- flush  input  1  synchronous empty request.
- write_data  input  DATA_WIDTH  word to push.
- write_enable  input  1  push request.
- read_enable  input  1  pop request.
- clear_errors  input  1  synchronous clear of overflow/underflow.
- read_data  output  DATA_WIDTH  popped word, registered.
- read_valid  output  1  read_data holds a newly popped word this cycle.
- level  output  ADDRESS_SIZE+1  number of stored words, 0..2**ADDRESS_SIZE.
- full, empty, almost_full, almost_empty  output  1 each  status flags.
- overflow, underflow  output  1 each  sticky error flags.

## Operation
- Storage: 2**ADDRESS_SIZE x DATA_WIDTH array, not reset; read-first on same-address collision.
- Pointers: write_pointer, read_pointer, ADDRESS_SIZE bits each, wrap naturally from 2**ADDRESS_SIZE-1 to 0.
- Acceptance uses registered flags only: write accepted = write_enable && !full; read accepted = read_enable && !empty.
- Write accepted: memory[write_pointer] <= write_data; write_pointer + 1.
- Read accepted: read_data <= memory[read_pointer]; read_pointer + 1; read_valid <= 1 next cycle. Otherwise read_valid <= 0 and read_data holds its last value.
- Level: +1 on write only, -1 on read only, unchanged on both or neither.
- Full and both requested: read accepted, write rejected. Empty and both requested: write accepted, read rejected.
- Flags, all registered and derived from next level: empty = (level == 0); full = (level == 2**ADDRESS_SIZE); almost_full = (level >= ALMOST_FULL_LEVEL); almost_empty = (level <= ALMOST_EMPTY_LEVEL).
- Overflow: set when write_enable && full. Underflow: set when read_enable && empty. Both stay set until clear_errors; a new error in the same cycle as clear_errors wins (flag stays 1).
- Flush: pointers and level to 0, flags to reset values, read_valid <= 0 next cycle. Overrides any write or read in the same cycle. Memory and error flags untouched.

## Timing
- Reset values: read_data 0, read_valid 0, level 0, empty 1, full 0, almost_full 0, almost_empty 1, overflow 0, underflow 0, both pointers 0.
- Reset asserted mid-operation: outputs reach reset values immediately and asynchronously; stored words are discarded.
- Write to flag/level update: 1 clock (edge of the accepting cycle).
- Read latency: data and read_valid appear 1 clock after the accepting edge. A continuous read_enable on a non-empty FIFO gives one word per clock.
- Write-to-readable: a word written at edge N can be accepted for read at edge N+1 and appears at N+2.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then idle: all outputs at reset values; after 5 clocks still empty=1, level=0, read_valid=0.
- ADDRESS_SIZE=3, thresholds 6/2: write 0x001..0x008 -> level steps 1..8, almost_empty falls at level 3, almost_full rises at level 6, full=1 at 8. A 9th write sets overflow=1, level stays 8. Read 8 words -> 0x001..0x008 in order, each with read_valid one cycle after its read_enable.
- Wrap-around: repeat write 5 / read 5 for 4 rounds with incrementing data -> every word returned in order across pointer wrap, level ends 0.
- Simultaneous read and write at level 4 -> level stays 4; at full -> write rejected, overflow=1, level 7; at empty -> read rejected, underflow=1, level 1.
- Flush at level 5 with read_enable and write_enable high -> next cycle level 0, empty=1, read_valid=0. clear_errors asserted together with a new underflow -> underflow remains 1. clear_errors alone -> flags cleared.
- Asynchronous reset pulsed between clock edges at level 6 -> outputs return to reset values before the next edge; a subsequent write/read returns the new data only.

Source files
------------

// File: rtl/pixel_fifo_if.sv
// Pixel FIFO handshake bundle: host-side push, scan-out pop, and the status/error flags.
interface pixel_fifo_if #(
  parameter int DATA_WIDTH   = 12,
  parameter int ADDRESS_SIZE = 13
);
  logic                    flush;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    write_enable;
  logic                    read_enable;
  logic                    clear_errors;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_valid;
  logic [ADDRESS_SIZE:0]   level;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output flush, write_data, write_enable, read_enable, clear_errors,
    input  read_data, read_valid, level, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  flush, write_data, write_enable, read_enable, clear_errors,
    output read_data, read_valid, level, full, empty, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/pixel_fifo.sv
// Single-clock pixel FIFO: read data + read_valid one clock after an accepted pop.
// Pushes when full / pops when empty are dropped and latched in sticky overflow/underflow.
module pixel_fifo #(
  parameter int DATA_WIDTH         = 12,
  parameter int ADDRESS_SIZE       = 13,
  parameter int ALMOST_FULL_LEVEL  = 2**ADDRESS_SIZE - 16,
  parameter int ALMOST_EMPTY_LEVEL = 16
) (
  input logic         clock,
  input logic         reset,
  pixel_fifo_if.slave bus
);
  localparam int DEPTH = 2**ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE:0]   LEVEL_FULL = (ADDRESS_SIZE+1)'(DEPTH);
  localparam logic [ADDRESS_SIZE:0]   LEVEL_AF   = (ADDRESS_SIZE+1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDRESS_SIZE:0]   LEVEL_AE   = (ADDRESS_SIZE+1)'(ALMOST_EMPTY_LEVEL);
  localparam logic [ADDRESS_SIZE:0]   LEVEL_ONE  = (ADDRESS_SIZE+1)'(1);
  localparam logic [ADDRESS_SIZE-1:0] PTR_ONE    = ADDRESS_SIZE'(1);

  logic [DATA_WIDTH-1:0]   memory [DEPTH];
  logic [ADDRESS_SIZE-1:0] write_pointer;
  logic [ADDRESS_SIZE-1:0] read_pointer;
  logic [ADDRESS_SIZE:0]   level_q;
  logic [ADDRESS_SIZE:0]   level_next;
  logic [DATA_WIDTH-1:0]   read_data_q;
  logic                    read_valid_q;
  logic                    full_q;
  logic                    empty_q;
  logic                    almost_full_q;
  logic                    almost_empty_q;
  logic                    overflow_q;
  logic                    underflow_q;
  logic                    write_accept;
  logic                    read_accept;

  // Acceptance looks only at registered flags, so no input reaches an output combinationally.
  assign write_accept = bus.write_enable && !full_q  && !bus.flush;
  assign read_accept  = bus.read_enable  && !empty_q && !bus.flush;

  always_comb begin
    level_next = level_q;
    if (bus.flush)
      level_next = '0;
    else if (write_accept && !read_accept)
      level_next = level_q + LEVEL_ONE;
    else if (read_accept && !write_accept)
      level_next = level_q - LEVEL_ONE;
  end

  // Memory is left out of reset so it maps onto a plain dual-port RAM.
  always_ff @(posedge clock) begin
    if (write_accept)
      memory[write_pointer] <= bus.write_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_pointer  <= '0;
      read_pointer   <= '0;
      level_q        <= '0;
      read_data_q    <= '0;
      read_valid_q   <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (bus.flush) begin
        write_pointer <= '0;
        read_pointer  <= '0;
      end else begin
        if (write_accept)
          write_pointer <= write_pointer + PTR_ONE;
        if (read_accept)
          read_pointer <= read_pointer + PTR_ONE;
      end
      if (read_accept)
        read_data_q <= memory[read_pointer];
      read_valid_q   <= read_accept;
      level_q        <= level_next;
      empty_q        <= (level_next == '0);
      full_q         <= (level_next == LEVEL_FULL);
      almost_full_q  <= (level_next >= LEVEL_AF);
      almost_empty_q <= (level_next <= LEVEL_AE);
      // A fresh error in the clearing cycle keeps the flag set.
      overflow_q  <= (bus.write_enable && full_q)  || (overflow_q  && !bus.clear_errors);
      underflow_q <= (bus.read_enable  && empty_q) || (underflow_q && !bus.clear_errors);
    end
  end

  assign bus.read_data    = read_data_q;
  assign bus.read_valid   = read_valid_q;
  assign bus.level        = level_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_pixel_fifo.sv
// Directed bench for pixel_fifo at depth 8, thresholds 6/2, with a read-data scoreboard.
module tb_pixel_fifo;
  localparam int DW = 12;
  localparam int AS = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cycle_count = 0;
  int   pass_count  = 0;
  int   check_count = 0;
  int   exp_data[$];
  int   exp_cyc[$];

  pixel_fifo_if #(.DATA_WIDTH(DW), .ADDRESS_SIZE(AS)) bus ();

  pixel_fifo #(
    .DATA_WIDTH(DW), .ADDRESS_SIZE(AS),
    .ALMOST_FULL_LEVEL(6), .ALMOST_EMPTY_LEVEL(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle_count <= cycle_count + 1;

  task automatic check(input string name, input int actual, input int required);
    check_count++;
    if (actual == required) pass_count++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
  endtask

  task automatic check_status(input string tag, input int lvl, input int e, input int f,
                              input int af, input int ae);
    check({tag, ".level"}, int'(bus.level), lvl);
    check({tag, ".empty"}, int'(bus.empty), e);
    check({tag, ".full"}, int'(bus.full), f);
    check({tag, ".almost_full"}, int'(bus.almost_full), af);
    check({tag, ".almost_empty"}, int'(bus.almost_empty), ae);
  endtask

  // One clock: drive the request, step past the edge, then return to idle.
  task automatic cyc(input logic we, input int wd, input logic re, input logic fl, input logic ce);
    bus.write_enable = we;
    bus.write_data   = DW'(wd);
    bus.read_enable  = re;
    bus.flush        = fl;
    bus.clear_errors = ce;
    @(posedge clock);
    #1;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.flush        = 1'b0;
    bus.clear_errors = 1'b0;
  endtask

  // Called just after the accepting edge; the word must be valid for exactly this cycle.
  task automatic expect_read(input int d);
    exp_data.push_back(d);
    exp_cyc.push_back(cycle_count);
  endtask

  always @(negedge clock) begin
    if (bus.read_valid) begin
      if (exp_data.size() == 0) begin
        check("spurious_read_valid", 1, 0);
      end else begin
        int d;
        int c;
        d = exp_data.pop_front();
        c = exp_cyc.pop_front();
        check("read_data", int'(bus.read_data), d);
        check("read_latency_cycle", cycle_count, c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 1'b0; bus.write_data = '0; bus.write_enable = 1'b0;
    bus.read_enable = 1'b0; bus.clear_errors = 1'b0;
    #1 reset = 1'b1;
    #2;
    check_status("reset", 0, 1, 0, 0, 1);
    check("reset.overflow", int'(bus.overflow), 0);
    check("reset.underflow", int'(bus.underflow), 0);
    check("reset.read_valid", int'(bus.read_valid), 0);
    check("reset.read_data", int'(bus.read_data), 0);
    #9 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_status("idle", 0, 1, 0, 0, 1);
    check("idle.read_valid", int'(bus.read_valid), 0);

    // Fill: almost_empty drops at 3, almost_full rises at 6, full at 8.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, i, 0, 0, 0);
      check_status($sformatf("fill%0d", i), i, 0, int'(i == 8), int'(i >= 6), int'(i <= 2));
    end
    cyc(1, 9, 0, 0, 0);
    check_status("overfill", 8, 0, 1, 1, 0);
    check("overfill.overflow", int'(bus.overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 0, 0);
      expect_read(i);
      check($sformatf("drain%0d.level", i), int'(bus.level), 8 - i);
    end
    cyc(0, 0, 0, 0, 0);
    check("drain.underflow", int'(bus.underflow), 0);
    check_status("drained", 0, 1, 0, 0, 1);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 5; k++) cyc(1, 'h100 + r * 5 + k, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
        cyc(0, 0, 1, 0, 0);
        expect_read('h100 + r * 5 + k);
      end
    end
    cyc(0, 0, 0, 0, 0);
    check_status("wrap", 0, 1, 0, 0, 1);

    cyc(0, 0, 0, 0, 1);
    check("clear1.overflow", int'(bus.overflow), 0);
    check("clear1.underflow", int'(bus.underflow), 0);

    for (int v = 'h200; v <= 'h203; v++) cyc(1, v, 0, 0, 0);
    cyc(1, 'h204, 1, 0, 0);
    expect_read('h200);
    check("both_mid.level", int'(bus.level), 4);
    check("both_mid.overflow", int'(bus.overflow), 0);
    for (int v = 'h205; v <= 'h208; v++) cyc(1, v, 0, 0, 0);
    check_status("full_again", 8, 0, 1, 1, 0);
    cyc(1, 'h2FF, 1, 0, 0);
    expect_read('h201);
    check_status("both_full", 7, 0, 0, 1, 0);
    check("both_full.overflow", int'(bus.overflow), 1);
    for (int v = 'h202; v <= 'h208; v++) begin
      cyc(0, 0, 1, 0, 0);
      expect_read(v);
    end
    check_status("drain2", 0, 1, 0, 0, 1);
    cyc(1, 'h300, 1, 0, 0);
    check_status("both_empty", 1, 0, 0, 0, 1);
    check("both_empty.underflow", int'(bus.underflow), 1);
    check("both_empty.read_valid", int'(bus.read_valid), 0);

    for (int v = 'h301; v <= 'h304; v++) cyc(1, v, 0, 0, 0);
    cyc(1, 'h305, 1, 0, 0);
    expect_read('h300);
    check("pre_flush.level", int'(bus.level), 5);
    cyc(1, 'h3AA, 1, 1, 0);
    check_status("flush", 0, 1, 0, 0, 1);
    check("flush.read_valid", int'(bus.read_valid), 0);
    check("flush.overflow_kept", int'(bus.overflow), 1);
    check("flush.underflow_kept", int'(bus.underflow), 1);
    cyc(0, 0, 1, 0, 1);
    check("clear_vs_new.underflow", int'(bus.underflow), 1);
    check("clear_vs_new.overflow", int'(bus.overflow), 0);
    cyc(0, 0, 0, 0, 1);
    check("clear2.underflow", int'(bus.underflow), 0);

    for (int v = 'h400; v <= 'h406; v++) cyc(1, v, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    expect_read('h400);
    cyc(0, 0, 0, 0, 0);
    check_status("pre_reset", 6, 0, 0, 1, 0);
    #1 reset = 1'b1;
    #1;
    check_status("async_reset", 0, 1, 0, 0, 1);
    check("async_reset.read_data", int'(bus.read_data), 0);
    check("async_reset.read_valid", int'(bus.read_valid), 0);
    #1 reset = 1'b0;
    cyc(1, 'h500, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    expect_read('h500);
    cyc(0, 0, 1, 0, 0);
    check("post_reset.level", int'(bus.level), 0);
    check("post_reset.underflow", int'(bus.underflow), 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("scoreboard_drained", exp_data.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
